aes_key_schedule: RTL
=====================

// Module: aes_key_schedule
// PURPOSE
//  Iterative, parametrised AES key-expansion engine for AES-128/192/256.
//  Loads a cipher key on a start strobe and expands it at one 32-bit word per clock.
//  Stores all round keys in an internal register bank.
//  Serves any round key through a combinational read port.
//  Replaces the single-round, AES-128-only, combinational next-round-key block; feeds the round datapath.
// PARAMETERS
//  KEY_BITS  128  cipher key width; legal values 128/192/256 only, anything else -> elaboration $error
//  derived (localparam): NK=KEY_BITS/32 (4/6/8), NR=NK+6 (10/12/14), NW=4*(NR+1) (44/52/60)
// PORTS
//  clk          in   1         rising-edge clock; the only clock
//  rst_n        in   1         synchronous, active-low reset
//  start        in   1         one-cycle strobe: capture key_in, begin expansion
//  key_in       in   KEY_BITS  cipher key, w[0] in MSBs [KEY_BITS-1 -: 32]
//  busy         out  1         expansion in progress
//  keys_valid   out  1         all NR+1 round keys stored and readable
//  rd_round     in   4         round index to read, 0..NR
//  rd_key       out  128       round key rd_round = {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]
// BEHAVIOUR
//  Reset (rst_n==0 at clk edge):
//   - state<=IDLE, busy=0, keys_valid=0, word counter i<=0
//   - word bank need not be cleared; rd_key is forced to 0 while keys_valid=0
//   - reset mid-expansion aborts the expansion; the partial bank is never exposed
//  FSM states: IDLE, EXPAND, DONE.
//   - IDLE/DONE + start: load w[0..NK-1] from key_in, i<=NK, keys_valid<=0, busy<=1, ->EXPAND
//   - EXPAND: each cycle writes w[i] and increments i
//     - on writing i==NW-1: ->DONE, busy<=0, keys_valid<=1
//   - start while in EXPAND: ignored; no restart, key_in not sampled
//   - DONE without start: hold; keys_valid stays 1 indefinitely
//  Word rule, with temp=w[i-1]:
//   - i%NK==0: temp=SubWord(RotWord(temp))^{RCON[i/NK],24'h0}
//   - else if NK==8 and i%NK==4: temp=SubWord(temp)
//   - w[i]=w[i-NK]^temp
//   - RotWord rotates the word left by 1 byte; SubWord applies the AES S-box to each byte
//   - RCON[1..10]=01,02,04,08,10,20,40,80,1B,36 (only up to index 10 is reachable)
//  Latency: start sampled at edge T -> keys_valid first high after edge T+(NW-NK)
//   - AES-128: 40 cycles; AES-192: 46 cycles; AES-256: 52 cycles
//  Read port: purely combinational from the bank, zero latency
//   - rd_round>NR or keys_valid==0 -> rd_key=128'h0
//  start in DONE re-keys: keys_valid drops the cycle after start; old keys are no longer readable
//  Each word is computed in a single cycle: one 32-bit S-box path (4 byte S-boxes) plus XORs
// STRUCTURE
//  - Shared header aes_defs.vh: RCON table function, S-box function/table, NK/NR/NW derivation macros
//  - Shared header aes_defs.vh: FSM state encodings
//  - One sub-module: aes_sub_word (32-bit input -> 32-bit output, 4 byte S-boxes)
//    - instantiated once, shared by the RotWord and SubWord-only paths via a mux
//  - Word bank: NW x 32 register array; a single write port indexed by i
//  - Round-key read port: 4-word read mux indexed by rd_round
// TESTING
//  1. KEY_BITS=128, key 5468617473206D79204B756E67204675, start:
//     - busy=1 for 40 cycles, then keys_valid=1
//     - rd_round=0 -> same value as key
//     - rd_round=1 -> E232FCF191129188B159E4E6D679A293
//     - rd_round=3 -> D2600DE7157ABC686339E901C3031EFB
//  2. KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c:
//     - rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
//     - rd_round=11 -> 0
//  3. KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//     - keys_valid after 46 cycles
//     - rd_round=12 -> e98ba06f448c773c8ecc720401002202
//  4. KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//     - keys_valid after 52 cycles
//     - rd_round=14 -> fe4890d1e6188d0b046df344706c631e
//  5. Start pulsed again 10 cycles into an expansion, with a different key_in:
//     - ignored; the results match the first key; keys_valid after the original 40 cycles
//  6. rst_n=0 for one cycle at expansion cycle 20:
//     - busy=0, keys_valid=0, rd_key=0
//     - a new start then completes normally, and case 1 values are met

Source files
------------

// File: rtl/aes_key_schedule_pkg.sv
// Shared AES key-schedule definitions: FSM encoding, S-box table and round-constant lookup.
package aes_key_schedule_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Row-major S-box; entry x sits at bits [8*(255-x) +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_schedule_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_sub_word
    import aes_key_schedule_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one 32-bit word per clock, with a
// combinational round-key read port over the stored word bank.
module aes_key_schedule
    import aes_key_schedule_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                keys_valid,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK_W    = 6'(NK);
    localparam logic [5:0] LAST_W  = 6'(NW - 1);
    localparam logic [2:0] NK_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_R    = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    state_t      state;
    logic [5:0]  i;
    logic [2:0]  pos;      // i % NK, tracked incrementally
    logic [3:0]  rc_idx;   // i / NK for the next RotWord word
    logic [31:0] bank [NW];

    logic [31:0] prev_w, back_w, sw_in, sw_out, temp, next_w;
    logic [5:0]  rd_base;

    assign prev_w = bank[i - 6'd1];
    assign back_w = bank[i - NK_W];

    // One shared S-box path: rotated input on RotWord words, raw input otherwise.
    always_comb begin
        sw_in = prev_w;
        if (pos == 3'd0) begin
            sw_in = {prev_w[23:0], prev_w[31:24]};
        end
    end

    aes_sub_word u_sub_word (
        .word_in  (sw_in),
        .word_out (sw_out)
    );

    always_comb begin
        temp = prev_w;
        if (pos == 3'd0) begin
            temp = sw_out ^ {rcon(rc_idx), 24'h0};
        end else if (NK == 8 && pos == 3'd4) begin
            temp = sw_out;
        end
        next_w = back_w ^ temp;
    end

    // start is a one-cycle strobe honoured only in IDLE or DONE; while busy it
    // is ignored and key_in is not sampled. keys_valid marks a complete bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            i          <= 6'd0;
            pos        <= 3'd0;
            rc_idx     <= 4'd1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            bank[k] <= key_in[KEY_BITS-1-32*k -: 32];
                        end
                        i          <= NK_W;
                        pos        <= 3'd0;
                        rc_idx     <= 4'd1;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    bank[i] <= next_w;
                    i       <= i + 6'd1;
                    pos     <= (pos == NK_LAST) ? 3'd0 : pos + 3'd1;
                    if (pos == 3'd0) begin
                        rc_idx <= rc_idx + 4'd1;
                    end
                    if (i == LAST_W) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_base = {rd_round, 2'b00};

    always_comb begin
        rd_key = 128'h0;
        if (keys_valid && rd_round <= NR_R) begin
            rd_key = {bank[rd_base], bank[rd_base + 6'd1],
                      bank[rd_base + 6'd2], bank[rd_base + 6'd3]};
        end
    end

endmodule
